lamp_fpu_exp2: RTL

- Multi-cycle bfloat16 base-2 exponential unit (2^x), the inverse of the FPU log2 unit.
- Same operand/result handshake and unpacked-field interface as the log unit.
- The testbench can chain log2 → exp2 for round-trip checks.
- Sits beside the log unit in the lampFPU datapath: sign/exponent/fraction in, sign/exponent/fraction plus flags out.

---
 rtl/lamp_fpu_exp2_pkg.sv | 43 ++++
 rtl/lamp_fpu_exp2_if.sv | 32 +++
 rtl/lamp_fpu_exp2_lut.sv | 22 ++
 rtl/lamp_fpu_exp2.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lamp_fpu_exp2_pkg.sv
// lampFPU exp2 shared definitions: field widths, constants, FSM/result enums and mantissa ROM generator.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lamp_fpu_exp2_pkg;

  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  localparam int EXP2_BIAS      = 127;
  localparam int EXP2_MAX_SHIFT = 6;
  localparam int EXP2_MIN_E     = 120;
  localparam int EXP2_FIX_W     = 16;
  localparam int EXP2_LUT_AW    = 7;

  localparam logic [LAMP_FLOAT_E_DW-1:0] EXP2_E_INF  = 8'hFF;
  localparam logic [LAMP_FLOAT_E_DW-1:0] EXP2_E_ONE  = 8'd127;
  localparam logic [LAMP_FLOAT_F_DW-1:0] EXP2_F_QNAN = 7'h40;

  typedef enum logic [2:0] {ST_IDLE, ST_CONV, ST_LUT, ST_PACK, ST_DONE} exp2_state_t;

  // Result class decided during conversion; SP_NONE means "use the LUT path".
  typedef enum logic [2:0] {SP_NONE, SP_OVF, SP_UNF, SP_NAN, SP_INF, SP_ZERO, SP_ONE} exp2_spec_t;

  // round(2^(r/128)*128) - 128, evaluated with a Q30 Taylor series of exp(r*ln2/128).
  // Only ever called with constant arguments, so it folds to a table at elaboration.
  function automatic logic [6:0] exp2_lut_val(input int unsigned r);
    longint unsigned y;
    longint unsigned term;
    longint unsigned sum;
    logic [63:0]     t;
    y    = (64'(r) * 64'd744261118) >> 7;  // r * ln2 / 128 in Q30
    term = 64'd1 << 30;
    sum  = 64'd1 << 30;
    for (int k = 1; k <= 12; k++) begin
      term = ((term * y) >> 30) / 64'(k);
      sum  = sum + term;
    end
    t = ((sum + (64'd1 << 22)) >> 23) - 64'd128;
    return t[6:0];
  endfunction

endpackage

// File: rtl/lamp_fpu_exp2_if.sv
// Operand/result bundle between the lampFPU datapath and the exp2 unit.
// Latency: n/a (wiring only).
// Backpressure: none; start is level-sampled, result is a one-cycle valid pulse.
interface lamp_fpu_exp2_if;
  import lamp_fpu_exp2_pkg::*;

  logic                       doExp_i;
  logic [LAMP_FLOAT_S_DW-1:0] s_op_i;
  logic [LAMP_FLOAT_E_DW-1:0] e_op_i;
  logic [LAMP_FLOAT_F_DW-1:0] f_op_i;
  logic                       isZ_op_i;
  logic                       isInf_op_i;
  logic                       isSNAN_op_i;
  logic                       isQNAN_op_i;
  logic [LAMP_FLOAT_S_DW-1:0] s_res_o;
  logic [LAMP_FLOAT_E_DW-1:0] e_res_o;
  logic [LAMP_FLOAT_F_DW-1:0] f_res_o;
  logic                       valid_o;
  logic                       isOverflow_o;
  logic                       isUnderflow_o;
  logic                       isToRound_o;

  modport master (
    output doExp_i, s_op_i, e_op_i, f_op_i, isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i,
    input  s_res_o, e_res_o, f_res_o, valid_o, isOverflow_o, isUnderflow_o, isToRound_o
  );

  modport slave (
    input  doExp_i, s_op_i, e_op_i, f_op_i, isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i,
    output s_res_o, e_res_o, f_res_o, valid_o, isOverflow_o, isUnderflow_o, isToRound_o
  );
endinterface

// File: rtl/lamp_fpu_exp2_lut.sv
// 2^(r/128) mantissa ROM: 7-bit fraction index in, 7-bit stored mantissa (hidden bit dropped) out.
// Latency: combinational.
// Backpressure: none.
module lamp_fpu_exp2_lut
  import lamp_fpu_exp2_pkg::*;
#(
  parameter int LUT_AW = EXP2_LUT_AW
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [6:0]        data
);

  logic [6:0] rom [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    localparam logic [6:0] VAL = exp2_lut_val(i);
    assign rom[i] = VAL;
  end

  assign data = rom[addr];

endmodule

// File: rtl/lamp_fpu_exp2.sv
// bfloat16 2^x unit: IDLE->CONV->LUT->PACK->DONE; optional RNE conversion via LAMP_FPU_EXP2_RNE_EN.
// Latency: doExp_i sampled at edge k -> valid_o high in the cycle after edge k+4; one op per 5 cycles.
// Backpressure: none; doExp_i is ignored outside IDLE, results hold until the next completion.
module lamp_fpu_exp2
  import lamp_fpu_exp2_pkg::*;
#(
  parameter int LUT_AW = EXP2_LUT_AW
) (
  input logic             clk,
  input logic             rst,
  lamp_fpu_exp2_if.slave  bus
);

  exp2_state_t state, state_nxt;
  logic op_load, conv_en, lut_en, pack_en, out_load;

  // operand, conversion, lookup and pack stage registers
  logic                 op_s, op_z, op_inf, op_nan;
  logic [7:0]           op_e;
  logic [6:0]           op_f;
  logic [15:0]          x_q;
  exp2_spec_t           spec_q;
  logic                 rnd_q;
  logic signed [9:0]    expsum_q;
  logic [6:0]           mant_q;
  logic [7:0]           pk_e;
  logic [6:0]           pk_f;
  logic                 pk_ovf, pk_unf, pk_rnd;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: fixed walk through the stages once started
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.doExp_i) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_LUT;
      ST_LUT:  state_nxt = ST_PACK;
      ST_PACK: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: one load enable per stage
  always_comb begin
    op_load  = (state == ST_IDLE) && bus.doExp_i;
    conv_en  = (state == ST_CONV);
    lut_en   = (state == ST_LUT);
    pack_en  = (state == ST_PACK);
    out_load = (state == ST_DONE);
  end

  // CONV: class/range decisions and Q8.7 fixed-point conversion of the operand
  logic [7:0]  mant_full;
  logic [20:0] wide;
  logic [13:0] xmag;
  logic [6:0]  dropped;
  logic        inexact;
  exp2_spec_t  spec_c;
  logic [15:0] x_c;

  assign mant_full = {1'b1, op_f};

  always_comb begin
    spec_c  = SP_NONE;
    wide    = '0;
    xmag    = '0;
    dropped = '0;
    inexact = 1'b0;
    if (op_nan)                                          spec_c = SP_NAN;
    else if (op_inf)                                     spec_c = op_s ? SP_ZERO : SP_INF;
    else if (op_z)                                       spec_c = SP_ONE;
    else if (op_e > 8'(EXP2_BIAS + EXP2_MAX_SHIFT))      spec_c = op_s ? SP_UNF : SP_OVF;
    else if (op_e < 8'(EXP2_MIN_E))                      inexact = 1'b1;
    else begin
      wide    = 21'(mant_full) << (op_e - 8'(EXP2_MIN_E));
      xmag    = wide[20:7];
      dropped = wide[6:0];
      inexact = |dropped;
`ifdef LAMP_FPU_EXP2_RNE_EN
      if (dropped[6] && ((|dropped[5:0]) || xmag[0])) xmag = xmag + 14'd1;
`endif
    end
    x_c = op_s ? (16'd0 - {2'b00, xmag}) : {2'b00, xmag};
  end

  // LUT: split X into integer n and fraction r
  logic [6:0]        lut_data;
  logic signed [9:0] expsum_c;

  lamp_fpu_exp2_lut #(.LUT_AW(LUT_AW)) u_lut (
    .addr (x_q[LUT_AW-1:0]),
    .data (lut_data)
  );

  assign expsum_c = $signed({x_q[15], x_q[15:7]}) + 10'sd127;

  // PACK: final exponent/fraction and status flags
  logic [7:0] pk_e_c;
  logic [6:0] pk_f_c;
  logic       pk_ovf_c, pk_unf_c, pk_rnd_c;

  always_comb begin
    pk_e_c   = '0;
    pk_f_c   = '0;
    pk_ovf_c = 1'b0;
    pk_unf_c = 1'b0;
    pk_rnd_c = 1'b0;
    case (spec_q)
      SP_NONE: begin
        pk_rnd_c = rnd_q;
        if (expsum_q >= 10'sd255) begin
          pk_e_c   = EXP2_E_INF;
          pk_ovf_c = 1'b1;
        end else if (expsum_q <= 10'sd0) begin
          pk_unf_c = 1'b1;
        end else begin
          pk_e_c = expsum_q[7:0];
          pk_f_c = mant_q;
        end
      end
      SP_OVF: begin
        pk_e_c   = EXP2_E_INF;
        pk_ovf_c = 1'b1;
      end
      SP_UNF:  pk_unf_c = 1'b1;
      SP_NAN: begin
        pk_e_c = EXP2_E_INF;
        pk_f_c = EXP2_F_QNAN;
      end
      SP_INF:  pk_e_c = EXP2_E_INF;
      SP_ONE:  pk_e_c = EXP2_E_ONE;
      default: pk_e_c = '0;
    endcase
  end

  // datapath and output registers; reset clears everything including results
  always_ff @(posedge clk) begin
    if (rst) begin
      {op_s, op_z, op_inf, op_nan, op_e, op_f} <= '0;
      x_q               <= '0;
      spec_q            <= SP_NONE;
      rnd_q             <= 1'b0;
      expsum_q          <= '0;
      mant_q            <= '0;
      {pk_e, pk_f}      <= '0;
      {pk_ovf, pk_unf, pk_rnd} <= '0;
      bus.s_res_o       <= '0;
      bus.e_res_o       <= '0;
      bus.f_res_o       <= '0;
      bus.valid_o       <= 1'b0;
      bus.isOverflow_o  <= 1'b0;
      bus.isUnderflow_o <= 1'b0;
      bus.isToRound_o   <= 1'b0;
    end else begin
      bus.valid_o <= out_load;
      if (op_load) begin
        op_s   <= bus.s_op_i[0];
        op_e   <= bus.e_op_i;
        op_f   <= bus.f_op_i;
        op_z   <= bus.isZ_op_i;
        op_inf <= bus.isInf_op_i;
        op_nan <= bus.isSNAN_op_i | bus.isQNAN_op_i;
      end
      if (conv_en) begin
        x_q    <= x_c;
        spec_q <= spec_c;
        rnd_q  <= inexact;
      end
      if (lut_en) begin
        expsum_q <= expsum_c;
        mant_q   <= lut_data;
      end
      if (pack_en) begin
        pk_e   <= pk_e_c;
        pk_f   <= pk_f_c;
        pk_ovf <= pk_ovf_c;
        pk_unf <= pk_unf_c;
        pk_rnd <= pk_rnd_c;
      end
      if (out_load) begin
        bus.s_res_o       <= '0;
        bus.e_res_o       <= pk_e;
        bus.f_res_o       <= pk_f;
        bus.isOverflow_o  <= pk_ovf;
        bus.isUnderflow_o <= pk_unf;
        bus.isToRound_o   <= pk_rnd;
      end
    end
  end

endmodule
